// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, shift FSM states and the flag bundle.
// The shift-op predicate lives here so the core and the top agree on which ops iterate.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_LD  = 5'h01,
        OP_ADD = 5'h03,
        OP_SUB = 5'h04,
        OP_AND = 5'h05,
        OP_OR  = 5'h06,
        OP_XOR = 5'h07,
        OP_NOT = 5'h08,
        OP_SL  = 5'h09,
        OP_SR  = 5'h0A,
        OP_ADC = 5'h0B,
        OP_SBC = 5'h0C,
        OP_ASR = 5'h0D,
        OP_CMP = 5'h0E
    } opcode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == OP_SL) || (op == OP_SR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for every single-step operation, including zero-distance shifts.
// Add and subtract paths are WIDTH+1 bits so the carry-out is bit WIDTH of the sum.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output flags_t           flags,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic             add_cin;
    logic             sub_cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_v;
    logic             sub_v;
    logic             c_bit;
    logic             v_bit;
    logic [WIDTH-1:0] zn_src;

    // Subtraction is A + ~B + cin so C reads as "no borrow".
    assign add_cin = (opcode == OP_ADC) ? cin : 1'b0;
    assign sub_cin = (opcode == OP_SBC) ? cin : 1'b1;
    assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, sub_cin};
    assign add_v   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
    assign sub_v   = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);

    always_comb begin
        result  = '0;
        c_bit   = 1'b0;
        v_bit   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_LD, OP_SL, OP_SR, OP_ASR: result = a;
            OP_ADD, OP_ADC: begin
                result = add_sum[MSB:0];
                c_bit  = add_sum[WIDTH];
                v_bit  = add_v;
            end
            OP_SUB, OP_SBC: begin
                result = sub_sum[MSB:0];
                c_bit  = sub_sum[WIDTH];
                v_bit  = sub_v;
            end
            OP_CMP: begin
                result = a;
                c_bit  = sub_sum[WIDTH];
                v_bit  = sub_v;
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: illegal = 1'b1;
        endcase
        // CMP passes A through but reports Z/N of the difference.
        zn_src  = (opcode == OP_CMP) ? sub_sum[MSB:0] : result;
        flags.z = (zn_src == '0);
        flags.n = zn_src[MSB];
        flags.c = c_bit;
        flags.v = v_bit;
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with input/output handshakes, a persistent carry bit and one-bit-per-cycle
// shifts for non-zero distances.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       instruction,
    input  logic [WIDTH-1:0] bus_A,
    input  logic [WIDTH-1:0] bus_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bus,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t           state_q;
    state_t           state_d;
    logic             slot_free;
    logic             accept;
    logic [SHW-1:0]   amt;

    logic [WIDTH-1:0] sh_reg;
    logic [4:0]       sh_op;
    logic [SHW-1:0]   sh_cnt;
    logic             sh_c;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic [WIDTH-1:0] fin_val;
    logic             fin_c;

    logic             cflag;
    flags_t           flags_q;

    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;
    logic             core_ill;

    logic             load_sh;
    logic             step;
    logic             fin_core;
    logic             fin_sh;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready, a result
    // transfers on a rising edge where out_valid && out_ready; out_* hold while stalled.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign amt       = bus_B[SHW-1:0];
    assign busy      = (state_q == SHIFT);

    assign Z = flags_q.z;
    assign N = flags_q.n;
    assign C = flags_q.c;
    assign V = flags_q.v;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .opcode (instruction),
        .a      (bus_A),
        .b      (bus_B),
        .cin    (cflag),
        .result (core_res),
        .flags  (core_flags),
        .illegal(core_ill)
    );

    always_comb begin
        step_val = {1'b0, sh_reg[WIDTH-1:1]};
        step_bit = sh_reg[0];
        case (sh_op)
            OP_SL: begin
                step_val = {sh_reg[WIDTH-2:0], 1'b0};
                step_bit = sh_reg[WIDTH-1];
            end
            OP_ASR:  step_val = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
            default: step_val = {1'b0, sh_reg[WIDTH-1:1]};
        endcase
    end

    // The final step and the result register share an edge, so a distance-s shift shows
    // its result s+1 cycles after acceptance; a stalled shift parks with the counter at 0.
    assign fin_val = (sh_cnt != '0) ? step_val : sh_reg;
    assign fin_c   = (sh_cnt != '0) ? step_bit : sh_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_sh  = 1'b0;
        step     = 1'b0;
        fin_core = 1'b0;
        fin_sh   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift_op(instruction) && (amt != '0)) begin
                        load_sh = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        fin_core = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (sh_cnt != '0) begin
                    step = 1'b1;
                    if ((sh_cnt == CNT_ONE) && slot_free) begin
                        fin_sh  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (slot_free) begin
                    fin_sh  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_reg <= '0;
            sh_op  <= 5'h00;
            sh_cnt <= '0;
            sh_c   <= 1'b0;
        end else if (load_sh) begin
            sh_reg <= bus_A;
            sh_op  <= instruction;
            sh_cnt <= amt;
            sh_c   <= 1'b0;
        end else if (step) begin
            sh_reg <= step_val;
            sh_cnt <= sh_cnt - CNT_ONE;
            sh_c   <= step_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bus   <= '0;
            flags_q   <= '0;
            illegal   <= 1'b0;
            cflag     <= 1'b0;
        end else if (fin_core) begin
            out_valid <= 1'b1;
            out_bus   <= core_res;
            flags_q   <= core_flags;
            illegal   <= core_ill;
            if (!core_ill) begin
                cflag <= core_flags.c;
            end
        end else if (fin_sh) begin
            out_valid <= 1'b1;
            out_bus   <= fin_val;
            flags_q.z <= (fin_val == '0);
            flags_q.n <= fin_val[WIDTH-1];
            flags_q.c <= fin_c;
            flags_q.v <= 1'b0;
            illegal   <= 1'b0;
            cflag     <= fin_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a vector table for single results plus hand-written
// sequences for latency, throughput, backpressure and reset-during-shift.
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int EW = W + 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   instruction = 5'h00;
    logic [W-1:0] bus_A = '0;
    logic [W-1:0] bus_B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_bus;
    logic         Z, N, C, V;
    logic         illegal;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [4:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t vecs[26];

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .bus_A      (bus_A),
        .bus_B      (bus_B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bus    (out_bus),
        .Z          (Z),
        .N          (N),
        .C          (C),
        .V          (V),
        .illegal    (illegal),
        .busy       (busy)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic z, input logic n,
                                         input logic c, input logic v, input logic ill);
        return {ill, z, n, c, v, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every consumed result is popped against the expected queue
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h expected none",
                         {illegal, Z, N, C, V, out_bus});
            end else begin
                check("result", 64'({illegal, Z, N, C, V, out_bus}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks: called at posedge+#1, return at posedge+#1 after the accepting edge
    task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        instruction = op;
        bus_A       = a;
        bus_B       = b;
        in_valid    = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic measure(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        vecs[0]  = '{5'h03, 32'hFFFFFFFF, 32'h00000001, pk(32'h00000000, 1, 0, 1, 0, 0)};
        vecs[1]  = '{5'h0B, 32'h00000000, 32'h00000000, pk(32'h00000001, 0, 0, 0, 0, 0)};
        vecs[2]  = '{5'h04, 32'h80000000, 32'h00000001, pk(32'h7FFFFFFF, 0, 0, 1, 1, 0)};
        vecs[3]  = '{5'h0E, 32'h00000003, 32'h00000005, pk(32'h00000003, 0, 1, 0, 0, 0)};
        vecs[4]  = '{5'h01, 32'h12345678, 32'hFFFFFFFF, pk(32'h12345678, 0, 0, 0, 0, 0)};
        vecs[5]  = '{5'h05, 32'hF0F0F0F0, 32'hFF00FF00, pk(32'hF000F000, 0, 1, 0, 0, 0)};
        vecs[6]  = '{5'h06, 32'h0000000F, 32'h000000F0, pk(32'h000000FF, 0, 0, 0, 0, 0)};
        vecs[7]  = '{5'h07, 32'hAAAAAAAA, 32'hAAAAAAAA, pk(32'h00000000, 1, 0, 0, 0, 0)};
        vecs[8]  = '{5'h08, 32'h00000000, 32'h00000000, pk(32'hFFFFFFFF, 0, 1, 0, 0, 0)};
        vecs[9]  = '{5'h03, 32'h7FFFFFFF, 32'h00000001, pk(32'h80000000, 0, 1, 0, 1, 0)};
        vecs[10] = '{5'h0C, 32'h00000005, 32'h00000003, pk(32'h00000001, 0, 0, 1, 0, 0)};
        vecs[11] = '{5'h0B, 32'hFFFFFFFF, 32'hFFFFFFFF, pk(32'hFFFFFFFF, 0, 1, 1, 0, 0)};
        vecs[12] = '{5'h1F, 32'h00000005, 32'h00000006, pk(32'h00000000, 1, 0, 0, 0, 1)};
        vecs[13] = '{5'h0B, 32'h00000000, 32'h00000000, pk(32'h00000001, 0, 0, 0, 0, 0)};
        vecs[14] = '{5'h09, 32'h00000005, 32'h00000000, pk(32'h00000005, 0, 0, 0, 0, 0)};
        vecs[15] = '{5'h0C, 32'h00000000, 32'h00000000, pk(32'hFFFFFFFF, 0, 1, 0, 0, 0)};
        vecs[16] = '{5'h02, 32'h00000007, 32'h00000001, pk(32'h00000000, 1, 0, 0, 0, 1)};
        vecs[17] = '{5'h09, 32'h80000001, 32'h00000004, pk(32'h00000010, 0, 0, 0, 0, 0)};
        vecs[18] = '{5'h0D, 32'h80000000, 32'h0000001F, pk(32'hFFFFFFFF, 0, 1, 0, 0, 0)};
        vecs[19] = '{5'h0A, 32'h000000F0, 32'h00000007, pk(32'h00000001, 0, 0, 1, 0, 0)};
        vecs[20] = '{5'h09, 32'h00000001, 32'h00000021, pk(32'h00000002, 0, 0, 0, 0, 0)};
        vecs[21] = '{5'h0A, 32'h00000001, 32'h00000001, pk(32'h00000000, 1, 0, 1, 0, 0)};
        vecs[22] = '{5'h0D, 32'h40000000, 32'h00000002, pk(32'h10000000, 0, 0, 0, 0, 0)};
        vecs[23] = '{5'h0D, 32'h80000003, 32'h00000001, pk(32'hC0000001, 0, 1, 1, 0, 0)};
        vecs[24] = '{5'h0C, 32'h00000005, 32'h00000005, pk(32'h00000000, 1, 0, 1, 0, 0)};
        vecs[25] = '{5'h0E, 32'h80000000, 32'h00000001, pk(32'h80000000, 0, 0, 1, 1, 0)};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_bus", 64'(out_bus), 64'd0);
        check("rst_flags", 64'({Z, N, C, V, illegal}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // vector table, one result at a time so the carry chain follows table order
        for (int i = 0; i < 26; i++) begin
            exp_q.push_back(vecs[i].exp);
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            drain();
        end

        // latency: plain op takes 1 cycle
        exp_q.push_back(pk(32'h00000003, 0, 0, 0, 0, 0));
        send(5'h03, 32'h1, 32'h2);
        measure(lat, bc);
        check("add_latency", 64'(lat), 64'd1);
        check("add_busy_cycles", 64'(bc), 64'd0);
        drain();

        // latency: SL by 4 takes 5 cycles with busy high for 4
        exp_q.push_back(pk(32'h00000010, 0, 0, 0, 0, 0));
        send(5'h09, 32'h80000001, 32'h4);
        measure(lat, bc);
        check("sl4_latency", 64'(lat), 64'd5);
        check("sl4_busy_cycles", 64'(bc), 64'd4);
        drain();

        // back-to-back XOR at one per cycle
        out_ready = 1'b1;
        exp_q.push_back(pk(32'hFFFF0000, 0, 1, 0, 0, 0));
        exp_q.push_back(pk(32'hEEEE1111, 0, 1, 0, 0, 0));
        exp_q.push_back(pk(32'hDDDD2222, 0, 1, 0, 0, 0));
        exp_q.push_back(pk(32'hCCCC3333, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            instruction = 5'h07;
            bus_A       = 32'h11111111 * i;
            bus_B       = 32'hFFFF0000;
            in_valid    = 1'b1;
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            check("b2b_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        drain();

        // backpressure: output held, no acceptance while stalled
        out_ready = 1'b0;
        exp_q.push_back(pk(32'h0000EDCB, 0, 0, 0, 0, 0));
        send(5'h07, 32'h00001234, 32'h0000FFFF);
        instruction = 5'h07;
        bus_A       = 32'h0;
        bus_B       = 32'h1;
        in_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_bus", 64'(out_bus), 64'h0000EDCB);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(pk(32'h00000001, 0, 0, 0, 0, 0));
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // reset mid-shift: no result, carry cleared
        exp_q.push_back(pk(32'h00000000, 1, 0, 1, 0, 0));
        send(5'h03, 32'hFFFFFFFF, 32'h1);
        drain();
        send(5'h0A, 32'h000000F0, 32'h7);
        @(posedge clk);
        #1;
        check("rs_busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rs_out_valid", 64'(out_valid), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rs_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("rs_no_result", 64'(out_valid), 64'd0);
        exp_q.push_back(pk(32'h00000000, 1, 0, 0, 0, 0));
        send(5'h0B, 32'h0, 32'h0);
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
